// File: rtl/dly_pipe.sv
// Programmable one-shot pulse delay with DEPTH independent slots.
// MODE selects restart (0), queue (1) or ignore-while-busy (2) trigger handling.

module dly_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic         act,
  output logic         fire,
  output logic         act_nxt
);
  logic [W-1:0] c, c_nxt;

  assign act  = (c != '0);
  assign fire = (c == {{(W-1){1'b0}}, 1'b1});

  // A load overrides the decrement, so an expiring slot can be reused on the same edge.
  always_comb begin
    c_nxt = c;
    if (ld)       c_nxt = d;
    else if (act) c_nxt = c - {{(W-1){1'b0}}, 1'b1};
  end

  assign act_nxt = (c_nxt != '0);

  always_ff @(posedge clk or negedge reset)
    if (!reset) c <= '0;
    else        c <= c_nxt;
endmodule

module dly_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in,
  input  logic [W-1:0]               dly,
  output logic                       p,
  output logic                       l,
  output logic                       ovf,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] act, fire, act_nxt, ld, free;
  logic [W-1:0]     d_eff;
  logic             drop, found;
  logic [CW-1:0]    cnt_nxt;

  assign d_eff = (dly == '0) ? {{(W-1){1'b0}}, 1'b1} : dly;
  assign free  = ~act | fire;

  always_comb begin
    ld    = '0;
    drop  = 1'b0;
    found = 1'b0;
    if (in) begin
      case (MODE)
        0: ld[0] = 1'b1;
        2: if (free[0]) ld[0] = 1'b1;
           else         drop  = 1'b1;
        default: begin
          for (int i = 0; i < DEPTH; i++)
            if (!found && free[i]) begin
              ld[i] = 1'b1;
              found = 1'b1;
            end
          drop = !found;
        end
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    dly_pipe_slot #(.W(W)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .ld      (ld[g]),
      .d       (d_eff),
      .act     (act[g]),
      .fire    (fire[g]),
      .act_nxt (act_nxt[g])
    );
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CW'(act_nxt[i]);
  end

  // Coincident expiries merge into a single p cycle.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      p   <= 1'b0;
      l   <= 1'b0;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      p   <= |fire;
      l   <= |act_nxt;
      ovf <= drop;
      cnt <= cnt_nxt;
    end
endmodule

// File: tb/tb_dly_pipe.sv
// Self-checking bench for dly_pipe: restart, queue and ignore instances share stimulus
// and are compared against a timestamp-based reference model.

module tb_dly_pipe;
  localparam int W = 8, DEPTH = 4;

  logic clk = 1'b0, reset = 1'b0, in = 1'b0;
  logic [W-1:0] dly = '0;
  logic p0, l0, o0, p1, l1, o1, p2, l2, o2;
  logic [2:0] c0, c1, c2;

  always #5 clk = ~clk;

  dly_pipe #(.W(W), .DEPTH(DEPTH), .MODE(0)) u_rst (
    .clk(clk), .reset(reset), .in(in), .dly(dly), .p(p0), .l(l0), .ovf(o0), .cnt(c0));
  dly_pipe #(.W(W), .DEPTH(DEPTH), .MODE(1)) u_que (
    .clk(clk), .reset(reset), .in(in), .dly(dly), .p(p1), .l(l1), .ovf(o1), .cnt(c1));
  dly_pipe #(.W(W), .DEPTH(DEPTH), .MODE(2)) u_ign (
    .clk(clk), .reset(reset), .in(in), .dly(dly), .p(p2), .l(l2), .ovf(o2), .cnt(c2));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: absolute fire times per pending pulse; -1 means no pulse pending.
  int n = 0;
  int q1[$];
  int t0 = -1, t2 = -1;
  logic ep0, el0, eo0, ep1, el1, eo1, ep2, el2, eo2;
  int ec0, ec1, ec2;

  task automatic model_edge(input logic t, input logic [W-1:0] d, input logic r);
    int dd;
    int keep[$];
    n++;
    dd = (d == 0) ? 1 : int'(d);
    {ep0, el0, eo0, ep1, el1, eo1, ep2, el2, eo2} = '0;
    if (!r) begin
      q1.delete(); t0 = -1; t2 = -1;
      ec0 = 0; ec1 = 0; ec2 = 0;
      return;
    end
    keep = {};
    foreach (q1[i]) if (q1[i] == n) ep1 = 1'b1; else keep.push_back(q1[i]);
    q1 = keep;
    if (t) begin
      if (q1.size() < DEPTH) q1.push_back(n + dd);
      else eo1 = 1'b1;
    end
    ec1 = q1.size(); el1 = (ec1 > 0);
    if (t0 == n) begin ep0 = 1'b1; t0 = -1; end
    if (t) t0 = n + dd;
    el0 = (t0 >= 0); ec0 = el0 ? 1 : 0;
    if (t2 == n) begin ep2 = 1'b1; t2 = -1; end
    if (t) begin
      if (t2 < 0) t2 = n + dd;
      else eo2 = 1'b1;
    end
    el2 = (t2 >= 0); ec2 = el2 ? 1 : 0;
  endtask

  task automatic step(input logic t, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    in = t; dly = d; reset = r;
    if (!r) begin
      #1;
      chk("async_clr", {p0, l0, o0, c0, p1, l1, o1, c1, p2, l2, o2, c2}, 0);
    end
    model_edge(t, d, r);
    @(posedge clk); #1;
    chk("r_p", p0, ep0); chk("r_l", l0, el0); chk("r_ovf", o0, eo0); chk("r_cnt", c0, ec0);
    chk("q_p", p1, ep1); chk("q_l", l1, el1); chk("q_ovf", o1, eo1); chk("q_cnt", c1, ec1);
    chk("i_p", p2, ep2); chk("i_l", l2, el2); chk("i_ovf", o2, eo2); chk("i_cnt", c2, ec2);
  endtask

  typedef struct {
    logic       t;
    logic [7:0] d;
    logic       p, l, o;
    logic [2:0] c;
  } vec_t;

  function automatic vec_t mk(logic t, logic [7:0] d, logic p, logic l, logic o, logic [2:0] c);
    vec_t v;
    v.t = t; v.d = d; v.p = p; v.l = l; v.o = o; v.c = c;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    // Queue-mode single pulse, merged pulse, and dly=0 treated as 1.
    tbl[0]  = mk(1, 5, 0, 1, 0, 1);
    for (int k = 1; k <= 4; k++) tbl[k] = mk(0, 0, 0, 1, 0, 1);
    tbl[5]  = mk(0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 6, 0, 1, 0, 1);
    tbl[8]  = mk(0, 0, 0, 1, 0, 1);
    tbl[9]  = mk(1, 4, 0, 1, 0, 2);
    for (int k = 10; k <= 12; k++) tbl[k] = mk(0, 0, 0, 1, 0, 2);
    tbl[13] = mk(0, 0, 1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 1, 0, 1);
    tbl[16] = mk(0, 0, 1, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_p", p1, 0); chk("rst_l", l1, 0); chk("rst_ovf", o1, 0); chk("rst_cnt", c1, 0);
    step(0, 0, 1);

    foreach (tbl[k]) begin
      step(tbl[k].t, tbl[k].d, 1);
      chk("tbl_p", p1, tbl[k].p); chk("tbl_l", l1, tbl[k].l);
      chk("tbl_ovf", o1, tbl[k].o); chk("tbl_cnt", c1, tbl[k].c);
    end

    // Back-to-back triggers, delay 4: three separate pulses, occupancy peaks at 3.
    for (int k = 0; k < 8; k++) begin
      step(k < 3, 4, 1);
      chk("b2b_p", p1, k >= 4 && k <= 6);
      if (k == 2) chk("b2b_cnt", c1, 3);
    end

    // Overflow: five triggers into four slots.
    repeat (5) step(0, 0, 1);
    for (int k = 0; k < 26; k++) begin
      step(k < 5, 20, 1);
      chk("ovf_pulse", o1, k == 4);
      chk("ovf_p", p1, k >= 20 && k <= 23);
    end

    // Restart vs ignore with triggers three cycles apart.
    repeat (5) step(0, 0, 1);
    for (int k = 0; k < 12; k++) begin
      step(k == 0 || k == 3, 5, 1);
      chk("rst_mode_p", p0, k == 8);
      chk("rst_mode_ovf", o0, 0);
      chk("ign_mode_p", p2, k == 5);
      chk("ign_mode_ovf", o2, k == 3);
    end

    // Reset mid-flight discards the pending pulse.
    repeat (5) step(0, 0, 1);
    for (int k = 0; k < 14; k++) begin
      step(k == 0 || k == 10, (k == 0) ? 8'd8 : 8'd0, !(k >= 2 && k <= 4));
      chk("rst_flight_p", p1, k == 11);
      if (k >= 2 && k <= 4) chk("rst_flight_l", l1, 0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      logic t, r;
      logic [W-1:0] d;
      t = ($urandom_range(0, 9) < 4);
      d = ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 60)) : W'($urandom_range(0, 8));
      r = ($urandom_range(0, 199) != 0);
      step(t, d, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dly_pipe.md
Name: dly_pipe

Overview:
- Parametrised successor to the fixed single-delay pulse units: one-shot pulse delay with runtime-programmable delay.
- In queue mode, up to DEPTH pulses can be in flight at once; restart and ignore-while-busy modes are also selectable.
- Provides busy-level, occupancy and overflow outputs for sequencing logic such as memory/bus timing chains and I/O handshakes.
- Replaces per-delay hand-written counters with one configurable block.

Parameters:
- W, 8: delay counter width; maximum delay 2^W-1 cycles.
- DEPTH, 4: number of independent delay slots (outstanding pulses); 1..16.
- MODE, 1: 0 = restart (a new trigger reloads the single active delay), 1 = queue (each trigger gets its own slot), 2 = ignore (triggers while busy are dropped).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted at 0); clears all state immediately.
- in  in  1  trigger, sampled at posedge; one trigger per cycle high.
- dly  in  W  delay in cycles, sampled in the same cycle as the trigger; 0 is treated as 1.
- p  out  1  registered one-cycle output pulse.
- l  out  1  registered busy level: any slot active.
- ovf  out  1  registered one-cycle pulse: trigger dropped.
- cnt  out  clog2(DEPTH+1)  registered count of active slots.

Behaviour:
- Reset values: p=0, l=0, ovf=0, cnt=0; all slots inactive, counters 0.
- Reset mid-operation discards all pending pulses; no p is produced after reset releases.
- Latency: trigger sampled high at edge t with effective delay D gives p=1 for exactly the cycle following edge t+D. Minimum latency is 1 cycle.
- Slot operation: an accepted trigger loads a free slot with D and marks it active.
- Each active slot decrements once per edge. A slot holding 1 at an edge expires on that edge: p<=1 and the slot is freed on the same edge.
- An expiring slot counts as free for a trigger on the same edge, in all modes.
- Coincident expiries (possible in queue mode when dly changes between triggers) produce one merged p cycle, free all expiring slots, and do not assert ovf.
- l and cnt reflect slot state after each edge. When the last slot expires, l falls on the same edge that p rises.
- MODE 0 (restart): only slot 0 is used.
  - Trigger while active reloads it with the new D; the earlier pulse never fires.
  - Trigger on the expiry edge: p fires for the old timing and the new delay starts.
  - ovf is never asserted.
- MODE 1 (queue): trigger goes to the lowest-index free slot.
  - If no slot is free and none expires on that edge, the trigger is dropped and ovf<=1 for one cycle.
- MODE 2 (ignore): only slot 0 is used.
  - Trigger while slot 0 is active and not expiring is dropped with ovf<=1.
  - Trigger on the expiry edge is accepted.
- Width rules: counters are W bits and never wrap, since loading stops at 1. cnt saturates naturally at DEPTH.
- in held high for N cycles counts as N triggers. There is no edge detection inside; use pg upstream if edge behaviour is needed.

Test Plan:
- MODE=1, dly=5, in high at edge 10 only -> p=1 only in the cycle after edge 15; l=1 from edge 10 to edge 15; cnt 1 then 0; ovf stays 0.
- MODE=1, dly=4, in at edges 10, 11, 12 -> p after edges 14, 15, 16 (three separate pulses); cnt peaks at 3 after edge 12.
- MODE=1, DEPTH=4, dly=20, in at edges 10..14 -> ovf pulse after edge 14 only; exactly 4 p pulses, after edges 30..33.
- MODE=1, in at edge 10 with dly=6, then edge 12 with dly=4 -> single merged p after edge 16; cnt 2 to 0 at edge 16.
- MODE=0, dly=5, in at edges 10 and 13 -> single p after edge 18, no ovf. MODE=2 with the same stimulus -> p after edge 15 and ovf after edge 13.
- MODE=1, in at edge 10 with dly=8; reset=0 from edge 12 to edge 14 -> all outputs 0 during reset, no p ever appears. Afterwards dly=0, in at edge 20 -> p after edge 21.
